// File: rtl/sr_regdump_uart.sv
// Debug register dump engine: walks pc and x1..x31 through the CPU debug port
// and streams each 32-bit value MSB-byte-first over an 8N1 UART.
module sr_regdump_uart #(
    parameter int CLK_DIV = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        txd,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        SEND
    } state_t;

    localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 1);

    state_t      state, stateNext;
    logic [15:0] bitCnt, bitCntNext;
    logic [3:0]  bitIdx, bitIdxNext;
    logic [1:0]  byteIdx, byteIdxNext;
    logic [31:0] word, wordNext;
    logic [4:0]  regAddrNext;
    logic        doneNext;
    logic        txdNext;
    logic [7:0]  byteSel;
    logic [9:0]  frame;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        stateNext   = state;
        bitCntNext  = bitCnt;
        bitIdxNext  = bitIdx;
        byteIdxNext = byteIdx;
        wordNext    = word;
        regAddrNext = regAddr;
        doneNext    = 1'b0;
        txdNext     = 1'b1;
        byteSel     = '0;
        frame       = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    stateNext   = ADDR;
                    regAddrNext = '0;
                end
            end
            ADDR: begin
                wordNext    = regData;
                stateNext   = SEND;
                bitCntNext  = '0;
                bitIdxNext  = '0;
                byteIdxNext = '0;
            end
            SEND: begin
                if (bitCnt == BIT_LAST) begin
                    bitCntNext = '0;
                    if (bitIdx == 4'd9) begin
                        bitIdxNext  = '0;
                        byteIdxNext = byteIdx + 2'd1;
                        if (byteIdx == 2'd3) begin
                            if (regAddr == 5'd31) begin
                                stateNext   = IDLE;
                                doneNext    = 1'b1;
                                regAddrNext = '0;
                            end else begin
                                stateNext   = ADDR;
                                regAddrNext = regAddr + 5'd1;
                            end
                        end
                    end else begin
                        bitIdxNext = bitIdx + 4'd1;
                    end
                end else begin
                    bitCntNext = bitCnt + 16'd1;
                end
            end
            default: stateNext = IDLE;
        endcase

        // txd is registered, so it is computed from the next-cycle bit position.
        case (byteIdxNext)
            2'd0:    byteSel = wordNext[31:24];
            2'd1:    byteSel = wordNext[23:16];
            2'd2:    byteSel = wordNext[15:8];
            default: byteSel = wordNext[7:0];
        endcase
        frame = {1'b1, byteSel, 1'b0};
        if (stateNext == SEND) begin
            txdNext = frame[bitIdxNext];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bitCnt  <= '0;
            bitIdx  <= '0;
            byteIdx <= '0;
            word    <= '0;
            regAddr <= '0;
            done    <= 1'b0;
            txd     <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state   <= stateNext;
            bitCnt  <= bitCntNext;
            bitIdx  <= bitIdxNext;
            byteIdx <= byteIdxNext;
            word    <= wordNext;
            regAddr <= regAddrNext;
            done    <= doneNext;
            txd     <= txdNext;
        end
    end

    assign busy = (state != IDLE);

endmodule
